// File: rtl/life_pkg.sv
// Shared definitions for the 16x16 life array and its host-side driver.
package life_pkg;

  localparam int ROWS  = 16;
  localparam int WIDTH = 16;
  localparam int SEL_W = 4;
  localparam int PER_W = 16;

  localparam logic [SEL_W-1:0] LAST_ROW = SEL_W'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STEP,
    S_SETTLE,
    S_FETCH,
    S_DUMP
  } drv_state_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] row;
    logic             last;
  } row_beat_t;

endpackage

// File: rtl/life_gen_timer.sv
// Generation period timer: counts IDLE cycles while run is high and fires
// once the count reaches max(period,1)-1. Any exit from counting clears it.
module life_gen_timer
  import life_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_run,
  input  logic             i_clr,
  input  logic [PER_W-1:0] i_period,
  output logic             o_fire
);

  logic [PER_W-1:0] r_cnt;
  logic [PER_W-1:0] w_limit;

  assign w_limit = (i_period == '0) ? '0 : i_period - 1'b1;
  assign o_fire  = i_en && i_run && (r_cnt == w_limit);

  // Period counter; held at zero whenever not counting or when firing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (!i_en || !i_run || i_clr || o_fire) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/life_array_driver.sv
// Host-side initiator for the 16x16 life array: pattern load, generation
// stepping (periodic or single), and a full-array dump after each generation.
// Optional macro LIFE_DRIVER_DELTA_EN adds dump_delta and gen_stable.
//
// state  | meaning
// IDLE   | waiting for a load, a single request or the run timer
// LOAD   | accepting row beats, writing them into the array
// STEP   | one-cycle generation advance pulse
// SETTLE | array state update cycle, row counter reset
// FETCH  | register the selected row for the dump beat
// DUMP   | present the dump beat until accepted
module life_array_driver
  import life_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             run,
  input  logic             single,
  input  logic [PER_W-1:0] period,
  output logic [WIDTH-1:0] arr_vali,
  output logic [SEL_W-1:0] arr_vali_sel,
  output logic             arr_write_enb,
  output logic             arr_step,
  output logic [SEL_W-1:0] arr_valo_sel,
  input  logic [WIDTH-1:0] arr_valo,
  input  logic [WIDTH-1:0] arr_valo_prev,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [WIDTH-1:0] dump_data,
  output logic [SEL_W-1:0] dump_row,
  output logic             dump_last,
  output logic [PER_W-1:0] gen_count,
  output logic             busy
`ifdef LIFE_DRIVER_DELTA_EN
  ,
  output logic [WIDTH-1:0] dump_delta,
  output logic             gen_stable
`endif
);

  drv_state_t       r_state, w_next;
  logic [SEL_W-1:0] r_row;
  logic [WIDTH-1:0] r_vali;
  logic [SEL_W-1:0] r_vali_sel;
  logic             r_wen;
  logic [PER_W-1:0] r_gen;
  row_beat_t        r_beat;
  logic             w_fire;
  logic             w_go_step;
  logic             w_stable;

  life_gen_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_en     (r_state == S_IDLE),
    .i_run    (run),
    .i_clr    (load_valid),
    .i_period (period),
    .o_fire   (w_fire)
  );

  assign w_go_step = single || (w_fire && !w_stable);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode and state-derived strobes.
  always_comb begin
    w_next     = r_state;
    load_ready = 1'b0;
    arr_step   = 1'b0;
    dump_valid = 1'b0;
    busy       = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (load_valid)     w_next = S_LOAD;
        else if (w_go_step) w_next = S_STEP;
      end
      S_LOAD: begin
        load_ready = 1'b1;
        if (load_valid && (r_row == LAST_ROW)) w_next = S_FETCH;
      end
      S_STEP: begin
        arr_step = 1'b1;
        w_next   = S_SETTLE;
      end
      S_SETTLE: w_next = S_FETCH;
      S_FETCH:  w_next = S_DUMP;
      S_DUMP: begin
        dump_valid = 1'b1;
        if (dump_ready) w_next = (r_row == LAST_ROW) ? S_IDLE : S_FETCH;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Row counter, array write port, generation counter and dump beat register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row      <= '0;
      r_vali     <= '0;
      r_vali_sel <= '0;
      r_wen      <= 1'b0;
      r_gen      <= '0;
      r_beat     <= '0;
    end else begin
      r_wen <= 1'b0;
      case (r_state)
        S_IDLE: r_row <= '0;
        S_LOAD: begin
          if (load_valid) begin
            r_vali     <= load_data;
            r_vali_sel <= r_row;
            r_wen      <= 1'b1;
            if (r_row == LAST_ROW) begin
              r_row <= '0;
              r_gen <= '0;
            end else begin
              r_row <= r_row + 1'b1;
            end
          end
        end
        S_STEP:   r_gen <= r_gen + 1'b1;
        S_SETTLE: r_row <= '0;
        S_FETCH: begin
          r_beat.data <= arr_valo;
          r_beat.row  <= r_row;
          r_beat.last <= (r_row == LAST_ROW);
        end
        S_DUMP: begin
          if (dump_ready && (r_row != LAST_ROW)) r_row <= r_row + 1'b1;
        end
        default: r_row <= '0;
      endcase
    end
  end

  assign arr_vali      = r_vali;
  assign arr_vali_sel  = r_vali_sel;
  assign arr_write_enb = r_wen;
  assign arr_valo_sel  = r_row;
  assign dump_data     = r_beat.data;
  assign dump_row      = r_beat.row;
  assign dump_last     = r_beat.last;
  assign gen_count     = r_gen;

`ifdef LIFE_DRIVER_DELTA_EN
  logic [WIDTH-1:0] r_delta;
  logic             r_stable;
  logic             r_all_zero;
  logic             r_after_step;

  // Stability only means something for a dump that follows a step; after a
  // load the previous-generation rows are unrelated to the new pattern.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_delta      <= '0;
      r_stable     <= 1'b0;
      r_all_zero   <= 1'b0;
      r_after_step <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_stable     <= 1'b0;
          r_all_zero   <= 1'b1;
          r_after_step <= 1'b0;
        end
        S_STEP: begin
          r_stable     <= 1'b0;
          r_all_zero   <= 1'b1;
          r_after_step <= 1'b1;
        end
        S_FETCH: begin
          r_delta <= arr_valo ^ arr_valo_prev;
          if ((arr_valo ^ arr_valo_prev) != '0) r_all_zero <= 1'b0;
        end
        S_DUMP: begin
          if (dump_ready && (r_row == LAST_ROW)) r_stable <= r_all_zero && r_after_step;
        end
        default: ;
      endcase
    end
  end

  assign dump_delta = r_delta;
  assign gen_stable = r_stable;
  assign w_stable   = r_stable;
`else
  logic w_unused_prev;
  assign w_unused_prev = ^arr_valo_prev;
  assign w_stable      = 1'b0;
`endif

endmodule

// File: tb/tb_life_array_driver.sv
// Bench for life_array_driver with a behavioural 16x16 life array model.
module tb_life_array_driver;
  import life_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic             load_valid, load_ready, run, single;
  logic [WIDTH-1:0] load_data;
  logic [PER_W-1:0] period;
  logic [WIDTH-1:0] arr_vali, arr_valo, arr_valo_prev;
  logic [SEL_W-1:0] arr_vali_sel, arr_valo_sel;
  logic             arr_write_enb, arr_step;
  logic             dump_valid, dump_ready, dump_last, busy;
  logic [WIDTH-1:0] dump_data;
  logic [SEL_W-1:0] dump_row;
  logic [PER_W-1:0] gen_count;
`ifdef LIFE_DRIVER_DELTA_EN
  logic [WIDTH-1:0] dump_delta;
  logic             gen_stable;
`endif

  life_array_driver dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .run(run), .single(single), .period(period),
    .arr_vali(arr_vali), .arr_vali_sel(arr_vali_sel), .arr_write_enb(arr_write_enb),
    .arr_step(arr_step), .arr_valo_sel(arr_valo_sel), .arr_valo(arr_valo),
    .arr_valo_prev(arr_valo_prev),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
    .dump_row(dump_row), .dump_last(dump_last), .gen_count(gen_count), .busy(busy)
`ifdef LIFE_DRIVER_DELTA_EN
    , .dump_delta(dump_delta), .gen_stable(gen_stable)
`endif
  );

  // Behavioural life array (dead cells beyond the edges).
  typedef logic [ROWS-1:0][WIDTH-1:0] grid_t;
  grid_t m_cur, m_prev;

  function automatic grid_t life_next(input grid_t g);
    grid_t n;
    int cnt;
    n = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < WIDTH; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < ROWS &&
                c + dc >= 0 && c + dc < WIDTH)
              cnt += int'(g[r+dr][c+dc]);
        n[r][c] = g[r][c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
      end
    end
    return n;
  endfunction

  initial begin
    m_cur  = '0;
    m_prev = '0;
  end

  always @(posedge clk) begin
    if (arr_write_enb) m_cur[arr_vali_sel] <= arr_vali;
    if (arr_step) begin
      m_prev <= m_cur;
      m_cur  <= life_next(m_cur);
    end
  end

  assign arr_valo      = m_cur[arr_valo_sel];
  assign arr_valo_prev = m_prev[arr_valo_sel];

  // Scoreboard.
  typedef struct {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] row;
    logic             last;
    logic [PER_W-1:0] gen;
    bit               chk_delta;
  } exp_t;

  exp_t  q[$];
  exp_t  e;
  int    n_cmp = 0, n_mis = 0;
  int    wr_cnt = 0, wr_base = 0, steps = 0, cyc = 0, step_last = 0, step_prev = 0;
  grid_t cur_load_pat;
  logic [3:0] wr_idx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_dump(input grid_t p, input int gen, input bit chk);
    exp_t x;
    for (int r = 0; r < ROWS; r++) begin
      x.data      = p[r];
      x.row       = SEL_W'(r);
      x.last      = (r == ROWS - 1);
      x.gen       = PER_W'(gen);
      x.chk_delta = chk;
      q.push_back(x);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: dump beats, array writes and step pulses.
  always @(negedge clk) begin
    if (reset) begin
      if (dump_valid && dump_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_mis++;
          $display("FAIL unexpected_beat: row %0d data 0x%0h with empty queue", dump_row, dump_data);
        end else begin
          e = q.pop_front();
          check("dump_data", 32'(dump_data), 32'(e.data));
          check("dump_row",  32'(dump_row),  32'(e.row));
          check("dump_last", 32'(dump_last), 32'(e.last));
          check("gen_count", 32'(gen_count), 32'(e.gen));
`ifdef LIFE_DRIVER_DELTA_EN
          if (e.chk_delta) check("dump_delta", 32'(dump_delta), 32'h0);
`endif
        end
      end
      if (arr_write_enb) begin
        wr_idx = 4'(wr_cnt - wr_base);
        check("wr_sel",  32'(arr_vali_sel), 32'(wr_idx));
        check("wr_data", 32'(arr_vali),     32'(cur_load_pat[wr_idx]));
        wr_cnt++;
      end
      if (arr_step) begin
        steps++;
        step_prev = step_last;
        step_last = cyc;
      end
      if (arr_step && arr_write_enb) check("step_and_write", 32'd1, 32'd0);
    end
  end

  task automatic load_beat(input logic [WIDTH-1:0] d);
    int k;
    load_valid = 1'b1;
    load_data  = d;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!load_ready && k < 20);
    if (k >= 20) check("load_ready_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
  endtask

  task automatic load_pattern(input grid_t p);
    cur_load_pat = p;
    wr_base = wr_cnt;
    for (int r = 0; r < ROWS; r++) begin
      load_beat(p[r]);
      if (r == 8) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((busy || q.size() != 0) && k < budget);
    if (k >= budget) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_steps(input int target, input int budget);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (steps < target && k < budget);
    if (k >= budget) check("step_timeout", 32'(steps), 32'(target));
  endtask

  task automatic pulse_single();
    @(posedge clk);
    #1;
    single = 1'b1;
    @(posedge clk);
    #1;
    single = 1'b0;
  endtask

  grid_t p_h, p_v, p_blk;
  int    s0, saved, k;

  initial begin
    p_h = '0; p_h[7] = 16'h0380;
    p_v = '0; p_v[6] = 16'h0100; p_v[7] = 16'h0100; p_v[8] = 16'h0100;
    p_blk = '0; p_blk[4] = 16'h0018; p_blk[5] = 16'h0018;
    cur_load_pat = '0;
    load_valid = 0; load_data = '0; run = 0; single = 0; period = '0; dump_ready = 1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    // Reset in the middle of a load (rows 0..4 accepted, row 5 next).
    wr_base = wr_cnt;
    for (int r = 0; r < 5; r++) load_beat(16'h0000);
    load_valid = 1'b1;
    reset = 1'b0;
    #1;
    check("rst_arr",  32'({arr_vali, arr_vali_sel, arr_write_enb, arr_step, arr_valo_sel}), 32'h0);
    check("rst_dump", 32'({dump_valid, dump_data, dump_row, dump_last}), 32'h0);
    check("rst_misc", 32'({load_ready, gen_count}), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
`ifdef LIFE_DRIVER_DELTA_EN
    check("rst_stable", 32'(gen_stable), 32'h0);
`endif
    load_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    saved = wr_cnt;
    repeat (5) @(posedge clk);
    #1;
    check("no_write_after_reset", 32'(wr_cnt), 32'(saved));
    check("idle_after_reset", 32'(busy), 32'h0);

    // Full load of a horizontal blinker; loaded pattern dumped with gen 0.
    push_dump(p_h, 0, 0);
    load_pattern(p_h);
    wait_idle(300);
    check("load_writes", 32'(wr_cnt - wr_base), 32'd16);

    // Single step.
    s0 = steps;
    push_dump(p_v, 1, 0);
    pulse_single();
    wait_idle(300);
    check("single_steps", 32'(steps - s0), 32'd1);

    // Run mode, period 10: 10 IDLE cycles + STEP + SETTLE + 32 dump cycles.
    s0 = steps;
    push_dump(p_h, 2, 0);
    push_dump(p_v, 3, 0);
    period = 16'd10;
    run = 1'b1;
    wait_steps(s0 + 2, 400);
    @(posedge clk);
    #1 run = 1'b0;
    check("period10_interval", 32'(step_last - step_prev), 32'd44);
    wait_idle(300);
    check("period10_steps", 32'(steps - s0), 32'd2);

    // Period 0 behaves as 1.
    s0 = steps;
    push_dump(p_h, 4, 0);
    push_dump(p_v, 5, 0);
    period = 16'd0;
    run = 1'b1;
    wait_steps(s0 + 2, 400);
    @(posedge clk);
    #1 run = 1'b0;
    check("period0_interval", 32'(step_last - step_prev), 32'd35);
    wait_idle(300);
    check("period0_steps", 32'(steps - s0), 32'd2);

    // Dump stall at row 3 for 20 cycles; a single during the stall is dropped.
    push_dump(p_h, 6, 0);
    pulse_single();
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(dump_valid && dump_row == 4'd2) && k < 200);
    if (k >= 200) check("row2_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1 dump_ready = 1'b0;
    s0 = steps;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 single = (i == 5);
      @(negedge clk);
      check("stall_valid", 32'(dump_valid), 32'd1);
      check("stall_row",   32'(dump_row),   32'd3);
      check("stall_data",  32'(dump_data),  32'h0);
      check("stall_last",  32'(dump_last),  32'd0);
    end
    single = 1'b0;
    check("no_step_in_stall", 32'(steps - s0), 32'd0);
    dump_ready = 1'b1;
    wait_idle(300);
    repeat (5) @(posedge clk);
    #1;
    check("single_in_dump_ignored", 32'(steps - s0), 32'd0);

`ifdef LIFE_DRIVER_DELTA_EN
    // Still life: first run step yields zero deltas, then run stops stepping.
    push_dump(p_blk, 0, 0);
    load_pattern(p_blk);
    s0 = steps;
    push_dump(p_blk, 1, 1);
    period = 16'd5;
    run = 1'b1;
    wait_steps(s0 + 1, 300);
    wait_idle(300);
    check("gen_stable_set", 32'(gen_stable), 32'd1);
    repeat (80) @(posedge clk);
    #1;
    check("run_suppressed", 32'(steps - s0), 32'd1);
    push_dump(p_blk, 2, 1);
    pulse_single();
    wait_idle(300);
    check("stable_single_steps", 32'(steps - s0), 32'd2);
    run = 1'b0;
`endif

    check("queue_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/life_array_driver.md
Name: life_array_driver

Overview:
- Host-side initiator for the 16x16 life array's row-access interface.
- Loads an initial pattern into the array from a valid/ready row stream.
- Issues generation `step` pulses, either on a programmable period or on demand.
- After every generation, reads the whole array back out as a 16-row valid/ready dump stream.

Parameters:
- ROWS, 16, number of array rows (one load/dump beat per row)
- WIDTH, 16, bits per row
- SEL_W, 4, row-selector width, equal to clog2(ROWS)
- PER_W, 16, width of the period and generation counters

Ports:
- clk  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- load_valid  in  1  load-row beat valid
- load_data  in  WIDTH  row value; rows arrive in order 0..ROWS-1
- load_ready  out  1  load beat accepted when valid&ready
- run  in  1  level; free-running generations while high
- single  in  1  one-cycle pulse; request exactly one generation
- period  in  PER_W  cycles between generations in run mode; 0 treated as 1
- arr_vali  out  WIDTH  row write data to array
- arr_vali_sel  out  SEL_W  row write select
- arr_write_enb  out  1  row write strobe
- arr_step  out  1  generation advance pulse
- arr_valo_sel  out  SEL_W  row read select
- arr_valo  in  WIDTH  selected row, current generation (combinational from array)
- arr_valo_prev  in  WIDTH  selected row, previous generation
- dump_valid  out  1  dump beat valid
- dump_ready  in  1  downstream accepts dump beat
- dump_data  out  WIDTH  row value
- dump_row  out  SEL_W  row index of the beat
- dump_last  out  1  high on row ROWS-1 beat
- gen_count  out  PER_W  generations stepped since last load; wraps
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values:
  - all outputs 0; FSM in IDLE; row counter, timer and gen_count cleared.
  - Reset mid-load or mid-dump abandons the operation immediately; no further array writes or steps occur.
- FSM states: IDLE, LOAD, STEP, SETTLE, FETCH, DUMP.
- IDLE:
  - load_ready=0.
  - Transition priority: load_valid -> LOAD; then (single, or run with timer==max(period,1)-1) -> STEP.
  - Timer increments each IDLE cycle while run=1, holds at 0 while run=0, and clears on leaving IDLE.
  - single outside IDLE is ignored (not queued).
- LOAD:
  - load_ready=1.
  - Each accepted beat registers arr_vali=load_data and arr_vali_sel=row, with arr_write_enb=1 on the following cycle only (one-cycle write latency).
  - Row counter increments per beat; gaps in load_valid are allowed.
  - After row ROWS-1 is accepted: gen_count cleared, go to FETCH, so the loaded pattern is dumped once (gen_count=0).
- STEP: arr_step=1 for exactly one cycle; gen_count+1 (wraps modulo 2^PER_W); next state SETTLE.
- SETTLE: one idle cycle for the array state to update; row counter cleared; next state FETCH.
- FETCH:
  - arr_valo_sel=row; dump_data<=arr_valo and dump_row<=row are registered; next state DUMP.
  - arr_valo_sel is driven from the row counter in every state.
- DUMP:
  - dump_valid=1; dump_data, dump_row and dump_last are held stable until dump_ready.
  - On handshake with row<ROWS-1: row+1, go to FETCH.
  - On handshake with row=ROWS-1: go to IDLE.
  - Throughput is one row per 2 cycles minimum.
- Timing guarantees:
  - arr_write_enb and arr_step are never high in the same cycle.
  - No step is issued while a dump is pending.

Optional Feature:
- Macro LIFE_DRIVER_DELTA_EN.
- When defined:
  - Adds output dump_delta[WIDTH], registered in FETCH as arr_valo^arr_valo_prev.
  - Adds output gen_stable, set in IDLE after a dump in which every row's delta was 0, and cleared on STEP or load.
  - While gen_stable=1, run-mode steps are suppressed; single still steps.
- When undefined: no extra ports; arr_valo_prev is unused.

Decomposition:
- Shared package life_pkg holds:
  - the FSM state enum;
  - ROWS, WIDTH and SEL_W constants, also used by the array side;
  - a row-beat struct {data, row, last}.
- One sub-module, life_gen_timer: the period counter with run gating and period==0 clamp, emitting a one-cycle fire pulse.

Test Plan:
- Reset held low mid-LOAD (row 5) -> all outputs 0 and busy=0; no arr_write_enb after reset release until a new load_valid.
- Load 16 rows, row 7=0x0380, others 0, with dump_ready=1 -> 16 arr_write_enb pulses with sel 0..15; then dump with gen_count=0, row7=0x0380, dump_last on row 15.
- Blinker single step -> exactly one arr_step; dump rows 6,7,8=0x0100, rest 0; gen_count=1.
- run=1, period=10, dump_ready=1 -> arr_step pulses every 10 IDLE cycles plus dump overhead; period=0 -> step after 1 IDLE cycle.
- dump_ready held low 20 cycles at row 3 -> dump_data/dump_row stable; no arr_step during stall; dump resumes on ready.
- With LIFE_DRIVER_DELTA_EN, load 2x2 block at rows 4-5=0x0018 with run=1 -> after first step, all dump_delta=0; gen_stable=1; run steps stop; single -> one step.
